// File: rtl/exec_result_buffer.sv
// exec_result_buffer
// Writeback-side stage that sits behind the execution unit. It remembers the
// destination register of each accepted op for one cycle, pairs it with the
// execution unit's registered result, and queues {rd, result} in a small FIFO
// that drains to the register-file write port under valid/ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   issue_valid  op presented to the execution unit this cycle
//   issue_rd     destination register of that op
//   issue_ready  space is guaranteed for this op's result
//   ex_result    execution unit result, valid the cycle after issue
//   wb_valid     head entry available
//   wb_rd        head destination register (0 when empty)
//   wb_data      head result (0 when empty)
//   wb_ready     register file accepts the head this cycle
//   fwd_rd       forwarding lookup register
//   fwd_hit      a pending value exists for fwd_rd
//   fwd_data     youngest pending value for fwd_rd
//   count        entries currently held in the FIFO
module exec_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] ex_result,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  input  logic [ADDR_W-1:0] fwd_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_rd_q, pend_rd_d;

  logic              issue_accept;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    inflight;
  logic [PTR_W-1:0]  fwd_idx;

  // Ready counts the in-flight op as already occupying a slot and takes no
  // credit for a pop in the same cycle, so the pending result always fits.
  assign inflight     = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_valid_q};
  assign issue_ready  = (inflight < DEPTH_C);
  assign issue_accept = issue_valid && issue_ready;

  // x0 results are dropped here but still held their in-flight slot above.
  assign push = pend_valid_q && (pend_rd_q != {ADDR_W{1'b0}});
  assign pop  = wb_valid && wb_ready;

  assign wb_valid = (count_q != {CNT_W{1'b0}});
  assign wb_rd    = wb_valid ? rd_mem_q[head_q]   : {ADDR_W{1'b0}};
  assign wb_data  = wb_valid ? data_mem_q[head_q] : {DATA_W{1'b0}};
  assign count    = count_q;

  // Next-state for pointers, occupancy and the one-deep pending tracker.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    pend_valid_d = issue_accept;
    pend_rd_d    = issue_accept ? issue_rd : pend_rd_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset drops queued entries and the in-flight op, which
  // also makes the result arriving right after reset a no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= {PTR_W{1'b0}};
      tail_q       <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      pend_valid_q <= 1'b0;
      pend_rd_q    <= {ADDR_W{1'b0}};
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
    end
  end

  // Entry storage; contents are only observed for slots inside count_q.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      rd_mem_q[tail_q]   <= pend_rd_q;
      data_mem_q[tail_q] <= ex_result;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins, then let
  // the not-yet-queued pending op override everything. The head being
  // popped this cycle is still inside count_q and so still forwardable.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    fwd_idx  = {PTR_W{1'b0}};
    if (fwd_rd != {ADDR_W{1'b0}}) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (rd_mem_q[fwd_idx] == fwd_rd)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem_q[fwd_idx];
        end else begin
          fwd_hit  = fwd_hit;
          fwd_data = fwd_data;
        end
      end
      if (pend_valid_q && (pend_rd_q == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = ex_result;
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end else begin
      fwd_hit  = 1'b0;
      fwd_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_exec_result_buffer.sv
// tb_exec_result_buffer
// Directed bench for exec_result_buffer (DEPTH=4, DATA_W=32, ADDR_W=5).
// Each step drives one cycle of inputs, checks outputs mid-cycle against a
// queue of expected {rd, data} entries plus hand-written forwarding values,
// then advances one clock.
module tb_exec_result_buffer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [31:0] ex_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic [4:0]  fwd_rd;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // expected FIFO contents and the expected in-flight op
  logic [36:0] q [$];
  logic        m_pend    = 1'b0;
  logic [4:0]  m_pend_rd = 5'd0;

  exec_result_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .ex_result(ex_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [4:0] ird, input logic [31:0] ex,
                      input logic wr, input logic [4:0] frd, input logic fh,
                      input logic [31:0] fd);
    logic        er;
    logic [36:0] head_e;
    issue_valid = iv;
    issue_rd    = ird;
    ex_result   = ex;
    wb_ready    = wr;
    fwd_rd      = frd;
    #1;
    er     = (q.size() + (m_pend ? 1 : 0)) < 4;
    head_e = (q.size() != 0) ? q[0] : 37'd0;
    chk("issue_ready", 64'(issue_ready), 64'(er));
    chk("count", 64'(count), 64'(q.size()));
    chk("count_le_depth", 64'(count <= 3'd4), 64'd1);
    chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
    chk("wb_rd", 64'(wb_rd), 64'(head_e[36:32]));
    chk("wb_data", 64'(wb_data), 64'(head_e[31:0]));
    chk("fwd_hit", 64'(fwd_hit), 64'(fh));
    chk("fwd_data", 64'(fwd_data), 64'(fd));
    @(posedge clk);
    if (q.size() != 0 && wr) void'(q.pop_front());
    if (m_pend && m_pend_rd != 5'd0) q.push_back({m_pend_rd, ex});
    m_pend    = iv && er;
    m_pend_rd = ird;
    #1;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0; ex_result = 32'd0;
    wb_ready = 1'b0; fwd_rd = 5'd3;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // single issue: rd=3, result 0x13, writeback two cycles later
    step(1'b1, 5'd3, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
    step(1'b0, 5'd0, 32'h13, 1'b1, 5'd3, 1'b1, 32'h13);
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_rd", 64'(wb_rd), 64'd3);
    chk("t1_wb_data", 64'(wb_data), 64'h13);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 32'h13);
    chk("t1_count_after_pop", 64'(count), 64'd0);

    // back-pressure: only rd 1..4 accepted while wb_ready=0
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 5'(k), 32'h100 + 32'(k - 1), 1'b0, 5'd0, 1'b0, 32'h0);
    end
    chk("bp_count_full", 64'(count), 64'd4);
    chk("bp_issue_ready", 64'(issue_ready), 64'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 1'b1, 32'h102);
    for (int j = 1; j <= 4; j++) begin
      chk("bp_drain_rd", 64'(wb_rd), 64'(j));
      chk("bp_drain_data", 64'(wb_data), 64'h100 + 64'(j));
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0);
    end
    chk("bp_count_empty", 64'(count), 64'd0);

    // x0 filter
    step(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 5'd5, 32'hFF, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b0, 5'd0, 32'h11, 1'b0, 5'd5, 1'b1, 32'h11);
    chk("x0_count", 64'(count), 64'd1);
    chk("x0_wb_rd", 64'(wb_rd), 64'd5);
    chk("x0_wb_data", 64'(wb_data), 64'h11);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0);
    chk("x0_count_empty", 64'(count), 64'd0);

    // forwarding priority
    step(1'b1, 5'd7, 32'h0, 1'b0, 5'd7, 1'b0, 32'h0);
    step(1'b1, 5'd7, 32'hA, 1'b0, 5'd7, 1'b1, 32'hA);
    step(1'b0, 5'd0, 32'hB, 1'b0, 5'd7, 1'b1, 32'hB);
    step(1'b1, 5'd7, 32'h0, 1'b0, 5'd7, 1'b1, 32'hB);
    step(1'b0, 5'd0, 32'hC, 1'b0, 5'd7, 1'b1, 32'hC);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b0, 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1, 32'hC);

    // simultaneous push and pop at count=3, then run across pointer wrap
    step(1'b1, 5'd8, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b0, 5'd0, 32'h208, 1'b1, 5'd8, 1'b1, 32'h208);
    chk("pp_count_held", 64'(count), 64'd3);
    for (int n = 0; n < 14; n++) begin
      step(1'b1, 5'(10 + n), 32'h300 + 32'(m_pend_rd), 1'b1, 5'd0, 1'b0, 32'h0);
    end
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 5'd0, 32'h300 + 32'(m_pend_rd), 1'b1, 5'd0, 1'b0, 32'h0);
    end
    chk("wrap_count_empty", 64'(count), 64'd0);

    // reset mid-stream with count=2 and an op in flight
    step(1'b1, 5'd1, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 5'd2, 32'h301, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 5'd3, 32'h302, 1'b0, 5'd0, 1'b0, 32'h0);
    chk("mr_count_before", 64'(count), 64'd2);
    issue_valid = 1'b0; rst = 1'b1; ex_result = 32'h55; wb_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ex_result = 32'h66; fwd_rd = 5'd3;
    #1;
    chk("mr_wb_valid", 64'(wb_valid), 64'd0);
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_issue_ready", 64'(issue_ready), 64'd1);
    chk("mr_fwd_hit", 64'(fwd_hit), 64'd0);
    q.delete();
    m_pend = 1'b0;
    step(1'b0, 5'd0, 32'h66, 1'b1, 5'd3, 1'b0, 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
    chk("mr_stale_dropped", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
